// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller with stall/flush performance counters
//
// Purpose:
//   Produces the PC / IF-ID / ID-EX / global freeze controls of a classic
//   five-stage pipeline. A busy data memory freezes everything, a load-use
//   dependency inserts exactly one ID/EX bubble, and a taken branch flushes
//   IF/ID. A branch that resolves while the memory is busy is remembered and
//   its flush is issued as soon as the pipeline moves again.
//
// Ports:
//   clk_i            in   clock, all state on rising edge
//   rst_i            in   synchronous active-high reset
//   mem_stall_i      in   data memory busy, freezes whole pipeline
//   id_ex_memread_i  in   instruction in EX is a load
//   id_ex_rt_i       in   [4:0] load destination register
//   if_id_rs_i       in   [4:0] ID source register rs
//   if_id_rt_i       in   [4:0] ID source register rt
//   branch_taken_i   in   branch/jump resolved taken in ID
//   clr_cnt_i        in   synchronous clear of both counters
//   pc_write_o       out  PC update enable
//   if_id_send_o     out  IF/ID load enable (0 = hold)
//   if_id_flush_o    out  IF/ID clear to NOP
//   pipe_stall_o     out  global freeze of all pipeline registers
//   id_ex_bubble_o   out  ID/EX control fields forced to zero
//   stall_cnt_o      out  [CNT_W-1:0] cycles with pc_write_o=0, saturating
//   flush_cnt_o      out  [CNT_W-1:0] flushes issued, saturating

module pipe_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mem_stall_i,
   input  logic             id_ex_memread_i,
   input  logic [4:0]       id_ex_rt_i,
   input  logic [4:0]       if_id_rs_i,
   input  logic [4:0]       if_id_rt_i,
   input  logic             branch_taken_i,
   input  logic             clr_cnt_i,
   output logic             pc_write_o,
   output logic             if_id_send_o,
   output logic             if_id_flush_o,
   output logic             pipe_stall_o,
   output logic             id_ex_bubble_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [1:0] ST_RUN = 2'd0;
   localparam logic [1:0] ST_LU  = 2'd1;
   localparam logic [1:0] ST_MEM = 2'd2;

   logic [1:0]       r_state;
   logic             r_flush_pend;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_hazard;
   logic [1:0]       w_next_state;

   // Register $zero never carries a real dependency.
   assign w_hazard = id_ex_memread_i & (id_ex_rt_i != 5'd0) &
                     ((id_ex_rt_i == if_id_rs_i) | (id_ex_rt_i == if_id_rt_i));

   always_comb begin
      pc_write_o     = 1'b0;
      if_id_send_o   = 1'b0;
      if_id_flush_o  = 1'b0;
      pipe_stall_o   = 1'b0;
      id_ex_bubble_o = 1'b0;
      w_next_state   = ST_RUN;
      if (rst_i) begin
         // Flushing IF/ID during reset guarantees a NOP on the first cycle out.
         if_id_flush_o = 1'b1;
      end else if (mem_stall_i) begin
         pipe_stall_o = 1'b1;
         w_next_state = ST_MEM;
      end else if (w_hazard && (r_state != ST_LU)) begin
         // Hazard is ignored in LU so a held load-use gets one bubble only.
         id_ex_bubble_o = 1'b1;
         w_next_state   = ST_LU;
      end else begin
         pc_write_o    = 1'b1;
         if_id_send_o  = 1'b1;
         if_id_flush_o = branch_taken_i | r_flush_pend;
         w_next_state  = ST_RUN;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_RUN;
         r_flush_pend <= 1'b0;
      end else begin
         r_state <= w_next_state;
         // A branch seen during a memory freeze would otherwise be lost.
         if (mem_stall_i && branch_taken_i)
            r_flush_pend <= 1'b1;
         else if (if_id_flush_o)
            r_flush_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_cnt_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!pc_write_o && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (if_id_flush_o && !(&r_flush_cnt))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;

endmodule
